// File: rtl/instr_mem_ctrl.sv
// instr_mem_ctrl: loadable, stallable instruction store feeding the IF stage.
// Optional IMEM_PARITY_EN adds a per-word even-parity bit and the if_perr flag.
module instr_mem_ctrl #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16,
  parameter logic [DATA_W-1:0] NOP_WORD = 16'h0000
) (
  input  logic              mem_clk,
  input  logic              rst_n,
  input  logic              load_start,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [DATA_W-1:0] ld_data,
  input  logic              ld_last,
  output logic              load_ovf,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_stall,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
`ifdef IMEM_PARITY_EN
  output logic              if_perr,
`endif
  output logic [ADDR_W:0]   prog_len
);

`ifdef IMEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif
  localparam logic [ADDR_W:0] WLAST = (ADDR_W+1)'((1 << ADDR_W) - 1);
  localparam logic [ADDR_W:0] FULL  = (ADDR_W+1)'(1 << ADDR_W);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t            state;
  logic [ADDR_W:0]   wptr;
  logic [MEM_W-1:0]  mem [2**ADDR_W];
  logic [MEM_W-1:0]  word_w;
  logic [MEM_W-1:0]  word_r;
  logic              wr_en;
  logic              in_range;

  // a load_start in LOAD discards the word handshaken that same cycle
  assign wr_en    = (state == LOAD) && ld_valid && !load_start;
  assign word_r   = mem[if_addr];
  assign in_range = {1'b0, if_addr} < prog_len;

`ifdef IMEM_PARITY_EN
  logic bad;
  assign word_w = {^ld_data, ld_data};
  assign bad    = ^word_r;
`else
  assign word_w = ld_data;
`endif

  always_ff @(posedge mem_clk) begin
    if (wr_en)
      mem[wptr[ADDR_W-1:0]] <= word_w;
  end

  always_ff @(posedge mem_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wptr     <= '0;
      ld_ready <= 1'b0;
      load_ovf <= 1'b0;
      prog_len <= '0;
      if_rdata <= NOP_WORD;
      if_valid <= 1'b0;
`ifdef IMEM_PARITY_EN
      if_perr  <= 1'b0;
`endif
    end else if (load_start) begin
      state    <= LOAD;
      wptr     <= '0;
      ld_ready <= 1'b1;
      load_ovf <= 1'b0;
      if_rdata <= NOP_WORD;
      if_valid <= 1'b0;
`ifdef IMEM_PARITY_EN
      if_perr  <= 1'b0;
`endif
    end else begin
      unique case (state)
        LOAD: begin
          if (ld_valid) begin
            if (ld_last) begin
              prog_len <= wptr + 1'b1;
              state    <= RUN;
              ld_ready <= 1'b0;
            end else if (wptr == WLAST) begin
              load_ovf <= 1'b1;
              prog_len <= FULL;
              state    <= RUN;
              ld_ready <= 1'b0;
            end else begin
              wptr <= wptr + 1'b1;
            end
          end
        end
        RUN: begin
          if (!if_stall) begin
            if_valid <= 1'b1;
`ifdef IMEM_PARITY_EN
            if (in_range && bad) begin
              if_rdata <= NOP_WORD;
              if_perr  <= 1'b1;
            end else begin
              if_rdata <= in_range ? word_r[DATA_W-1:0] : NOP_WORD;
              if_perr  <= 1'b0;
            end
`else
            if_rdata <= in_range ? word_r : NOP_WORD;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_ctrl.sv
// tb_instr_mem_ctrl: randomized load/fetch traffic against an array model.
// Define IMEM_PARITY_EN to also exercise the parity flag.
module tb_instr_mem_ctrl;

  logic        mem_clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic        ld_valid;
  logic        ld_ready;
  logic [15:0] ld_data;
  logic        ld_last;
  logic        load_ovf;
  logic [7:0]  if_addr;
  logic        if_stall;
  logic [15:0] if_rdata;
  logic        if_valid;
  logic [8:0]  prog_len;
`ifdef IMEM_PARITY_EN
  logic        if_perr;
`endif

  instr_mem_ctrl dut (
    .mem_clk    (mem_clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .ld_valid   (ld_valid),
    .ld_ready   (ld_ready),
    .ld_data    (ld_data),
    .ld_last    (ld_last),
    .load_ovf   (load_ovf),
    .if_addr    (if_addr),
    .if_stall   (if_stall),
    .if_rdata   (if_rdata),
    .if_valid   (if_valid),
`ifdef IMEM_PARITY_EN
    .if_perr    (if_perr),
`endif
    .prog_len   (prog_len)
  );

  always #5 mem_clk = ~mem_clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [15:0] mmem [256];
  int          plen;
  bit          movf;
  logic [15:0] erd;
  bit          ev;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge mem_clk);
    #1;
  endtask

  function automatic logic [15:0] ref_read(input int a);
    return (a < plen) ? mmem[a] : 16'h0000;
  endfunction

  task automatic run_cyc(input int a, input bit stall);
    if_addr  = 8'(a);
    if_stall = stall;
    step();
    if (!stall) begin
      erd = ref_read(a);
      ev  = 1'b1;
    end
    chk("if_rdata", 32'(if_rdata), 32'(erd));
    chk("if_valid", 32'(if_valid), 32'(ev));
  endtask

  task automatic start_load();
    load_start = 1'b1;
    step();
    load_start = 1'b0;
    erd  = 16'h0000;
    ev   = 1'b0;
    movf = 1'b0;
    chk("ld_ready_on", 32'(ld_ready), 32'd1);
    chk("rdata_ld", 32'(if_rdata), 32'h0);
    chk("valid_ld", 32'(if_valid), 32'd0);
  endtask

  task automatic send(input int idx, input logic [15:0] w, input bit last);
    ld_valid = 1'b1;
    ld_data  = w;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
    mmem[idx] = w;
  endtask

  task automatic finish_load(input int len, input bit ovf);
    plen = len;
    movf = ovf;
    chk("prog_len", 32'(prog_len), 32'(plen));
    chk("load_ovf", 32'(load_ovf), 32'(movf));
    chk("ld_ready_off", 32'(ld_ready), 32'd0);
  endtask

  task automatic load_prog(input logic [15:0] words[$], input bit use_last,
                           input bit gaps);
    int n = words.size();
    start_load();
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        ld_valid = 1'b0;
        ld_last  = 1'b1;
        ld_data  = 16'($urandom);
        step();
      end
      send(i, words[i], use_last && (i == n - 1));
    end
    finish_load(use_last ? n : 256, !use_last);
  endtask

  initial begin
    logic [15:0] q[$];
    logic [15:0] held;
    rst_n = 1'b0; load_start = 1'b0; ld_valid = 1'b0; ld_data = '0;
    ld_last = 1'b0; if_addr = '0; if_stall = 1'b0;
    plen = 0; movf = 0; erd = 0; ev = 0;
    #12;
    chk("rst_ready", 32'(ld_ready), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_rdata", 32'(if_rdata), 32'h0);
    chk("rst_ovf", 32'(load_ovf), 32'd0);
    chk("rst_plen", 32'(prog_len), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if_addr = '0;
      step();
      chk("idle_valid", 32'(if_valid), 32'd0);
      chk("idle_rdata", 32'(if_rdata), 32'h0);
    end

    q = '{16'h1A2B, 16'h23C0, 16'h5810};
    load_prog(q, 1'b1, 1'b0);
    for (int a = 0; a < 4; a++) run_cyc(a, 1'b0);

    q = {};
    for (int i = 0; i < 6; i++) q.push_back(16'($urandom));
    load_prog(q, 1'b1, 1'b1);
    for (int a = 0; a < 8; a++) run_cyc(a, 1'b0);

    run_cyc(2, 1'b0);
    held = if_rdata;
    for (int i = 0; i < 3; i++) begin
      run_cyc(i == 1 ? 0 : 4 + i, 1'b1);
      chk("stall_hold", 32'(if_rdata), 32'(held));
    end
    run_cyc(5, 1'b0);

    start_load();
    send(0, 16'h1111, 1'b0);
    send(1, 16'h2222, 1'b0);
    load_start = 1'b1;
    ld_valid = 1'b1;
    ld_data  = 16'hDEAD;
    step();
    load_start = 1'b0;
    ld_valid = 1'b0;
    send(0, 16'h3333, 1'b0);
    send(1, 16'h4444, 1'b1);
    finish_load(2, 1'b0);
    for (int a = 0; a < 4; a++) run_cyc(a, 1'b0);

    for (int r = 0; r < 6; r++) begin
      q = {};
      for (int i = 0; i < int'($urandom_range(1, 20)); i++)
        q.push_back(16'($urandom));
      load_prog(q, 1'b1, 1'($urandom));
      for (int c = 0; c < 30; c++)
        run_cyc(int'($urandom_range(0, 31)), $urandom_range(0, 3) == 0);
    end

    q = {};
    for (int i = 0; i < 256; i++) q.push_back(16'($urandom));
    load_prog(q, 1'b0, 1'b0);
    ld_valid = 1'b1;
    ld_data  = 16'hFFFF;
    run_cyc(0, 1'b0);
    run_cyc(255, 1'b0);
    run_cyc(128, 1'b0);
    run_cyc(0, 1'b0);
    ld_valid = 1'b0;

    start_load();
    send(0, 16'hAAAA, 1'b0);
    send(1, 16'hBBBB, 1'b0);
    rst_n = 1'b0;
    #1;
    plen = 0; erd = 0; ev = 0;
    chk("mid_rst_plen", 32'(prog_len), 32'd0);
    chk("mid_rst_ready", 32'(ld_ready), 32'd0);
    chk("mid_rst_valid", 32'(if_valid), 32'd0);
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 32'(if_valid), 32'd0);
    q = '{16'h7E57};
    load_prog(q, 1'b1, 1'b0);
    run_cyc(1, 1'b0);
    run_cyc(0, 1'b0);

`ifdef IMEM_PARITY_EN
    chk("perr_clean", 32'(if_perr), 32'd0);
    dut.mem[0] = dut.mem[0] ^ 17'h00001;
    if_addr = 8'd0;
    step();
    chk("perr_flag", 32'(if_perr), 32'd1);
    chk("perr_rdata", 32'(if_rdata), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem_ctrl.md
# instr_mem_ctrl

Parametrised instruction memory for the 5-stage CPU, replacing the fixed 256×16 case-initialised store. Adds a handshaked program-load port that fills the array sequentially from address 0, and a registered, stallable fetch port for the IF stage. A small state machine arbitrates between loading and fetching, so the same netlist runs any program without re-synthesis.

## Interface
- ADDR_W, 8, fetch/load address width; depth = 2^ADDR_W words
- DATA_W, 16, instruction width
- NOP_WORD, 16'h0000, word driven on if_rdata while not in RUN
- mem_clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- load_start  in  1  single-cycle pulse; begin a program load at address 0
- ld_valid  in  1  loader word present
- ld_ready  out  1  controller accepts word this cycle
- ld_data  in  DATA_W  instruction word to write
- ld_last  in  1  qualifies final word of the program
- load_ovf  out  1  sticky: load hit the last address without ld_last
- if_addr  in  ADDR_W  fetch address (PC)
- if_stall  in  1  hold if_rdata/if_valid (pipeline stall)
- if_rdata  out  DATA_W  fetched instruction
- if_valid  out  1  if_rdata is a real fetched instruction
- prog_len  out  ADDR_W+1  word count of the last completed load

## Operation
- States: IDLE, LOAD, RUN. Reset → IDLE.
- IDLE: ld_ready=0, if_valid=0, if_rdata=NOP_WORD. load_start → LOAD.
- LOAD: ld_ready=1. On ld_valid&&ld_ready: mem[wptr] ← ld_data, wptr++. Write counter wptr is ADDR_W+1 bits, cleared on entry.
  - ld_last accepted → prog_len ← wptr+1, go RUN.
  - Word accepted at address 2^ADDR_W−1 without ld_last → load_ovf ← 1, prog_len ← 2^ADDR_W, go RUN. No wrap to 0; no further writes.
  - load_start while in LOAD → restart: wptr ← 0, stay LOAD; the word (if any) handshaken that cycle is discarded.
- RUN: ld_ready=0. Synchronous read: if_rdata ← mem[if_addr] when !if_stall; if_valid ← 1 from the second RUN cycle on.
  - Addresses ≥ prog_len return NOP_WORD (if_valid still 1), so runaway PC executes NOPs.
  - load_start → LOAD; if_valid ← 0 and if_rdata ← NOP_WORD on the next edge.
- load_ovf clears only on load_start or reset.
- Array contents are not reset; rst_n mid-load → IDLE, wptr ← 0, prog_len ← 0, partial words stay in the array but are unreachable until the next completed load.

## Timing
- Reset values: ld_ready 0, if_valid 0, if_rdata NOP_WORD, load_ovf 0, prog_len 0.
- load_start at edge N → ld_ready=1 after edge N; first write possible at edge N+1.
- One write per cycle at full throughput.
- ld_last accepted at edge M → state RUN after M; the first read registers at M+1, so if_valid=1 after edge M+1.
- Fetch latency: if_addr sampled at edge K → if_rdata valid after K. Read-before-write does not arise, because there are no writes in RUN.
- if_stall=1 at an edge: if_rdata and if_valid unchanged; if_addr ignored.
- load_start and if_stall together in RUN: load_start wins.

## Configuration
- IMEM_PARITY_EN defined: each word stores an extra even-parity bit computed on write. New output if_perr (1 bit, reset 0) is registered with if_rdata. On a parity mismatch, if_perr=1 and if_rdata=NOP_WORD for that fetch.
- Not defined: no parity storage and no if_perr port; array width is DATA_W.

## Test plan
- Reset then idle: outputs as in Timing. Fetch if_addr=0 for 5 cycles → if_valid=0, if_rdata=16'h0000.
- Load 3 words 16'h1A2B, 16'h23C0, 16'h5810 (ld_last on the third), then fetch addresses 0,1,2,3 → read 1A2B, 23C0, 5810, 0000 at one-cycle latency; prog_len=3.
- Load with ld_valid toggled every other cycle → all words land at consecutive addresses; no writes when ld_valid=0.
- Fill all 256 words with no ld_last → load_ovf=1, prog_len=256, RUN entered; word 0 not overwritten.
- In RUN, assert if_stall for 3 cycles while changing if_addr → if_rdata frozen; next unstalled fetch returns the new address's data.
- Assert rst_n low after 2 of 4 load words, then reload 1 word → prog_len=1; fetch at addr 1 returns NOP_WORD. With IMEM_PARITY_EN, force-flip one stored bit → if_perr=1 and if_rdata=0000.
